// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - Wishbone classic single-transfer master with local decode reject and timeout
module wb_master_bridge #(
  parameter int ADR_W   = 26,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             req_we_i,
  input  logic [ADR_W-1:0] req_adr_i,
  input  logic [DAT_W-1:0] req_dat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [DAT_W-1:0] rdata_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] dat_i
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ADR_W-1:0] MEM_TOP  = ADR_W'(32'h0000_FFFF);
  localparam logic [ADR_W-1:0] WR_ONLY  = ADR_W'(32'h0001_0000);
  localparam logic [ADR_W-1:0] RD_ONLY  = ADR_W'(32'h0001_0001);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE, FAIL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [DAT_W-1:0]   rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               legal;

  // The downstream slave decodes only its memory window plus one write-only and one read-only register.
  assign legal = (req_adr_i <= MEM_TOP)
              || (req_we_i  && (req_adr_i == WR_ONLY))
              || (!req_we_i && (req_adr_i == RD_ONLY));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (legal) begin
            adr_d   = req_adr_i;
            dat_d   = req_dat_i;
            we_d    = req_we_i;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
          end else begin
            state_d = FAIL;
          end
        end
      end
      BUS: begin
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rdata_d = dat_i;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = FAIL;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_d == FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - self-checking bench for wb_master_bridge
module tb_wb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        req_we_i;
  logic [25:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [31:0] rdata_o, dat_o, dat_i;
  logic [25:0] adr_o;
  logic        ack_i;

  wb_master_bridge #(.ADR_W(26), .DAT_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic        busy;
    logic        done;
    logic        err;
    logic [25:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [25:0] m_adr   = '0;
  logic [31:0] m_dat   = '0;
  logic [31:0] m_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int run = 0, last_run = 0, low_run = 0, last_gap = 0;
  int done_cnt = 0, err_cnt = 0;

  function automatic exp_t mk(input logic cyc, input logic we, input logic busy,
                              input logic done, input logic err);
    exp_t e;
    e.cyc = cyc; e.we = we; e.busy = busy; e.done = done; e.err = err;
    e.adr = m_adr; e.dat = m_dat; e.rdata = m_rdata;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic bit decodes(input logic we, input logic [25:0] adr);
    return (adr < 26'h10000) || (we && adr == 26'h10000) || (!we && adr == 26'h10001);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected trace; an empty trace means the bridge must be idle.
  always @(negedge clk_i) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) e = q.pop_front();
    else e = idle_exp();
    a.cyc = cyc_o; a.we = we_o; a.busy = busy_o; a.done = done_o; a.err = err_o;
    a.adr = adr_o; a.dat = dat_o; a.rdata = rdata_o;
    n_chk++;
    if (a !== e || stb_o !== cyc_o) begin
      n_fail++;
      $display("FAIL trace t=%0t: got cyc=%b stb=%b we=%b busy=%b done=%b err=%b adr=%h dat=%h rdata=%h expected cyc=%b we=%b busy=%b done=%b err=%b adr=%h dat=%h rdata=%h",
               $time, a.cyc, stb_o, a.we, a.busy, a.done, a.err, a.adr, a.dat, a.rdata,
               e.cyc, e.we, e.busy, e.done, e.err, e.adr, e.dat, e.rdata);
    end
    if (stb_o) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
      low_run++;
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  end

  // Called post-edge in an IDLE cycle. k = strobe cycle carrying the ack, 0 = never ack.
  task automatic xfer(input logic we, input logic [25:0] adr, input logic [31:0] dat,
                      input int k, input logic [31:0] rd, input bit hold, input bit stray);
    bit legal;
    int n;
    legal = decodes(we, adr);
    n = (k == 0) ? TIMEOUT : k;
    q.push_back(idle_exp());
    if (!legal) begin
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    end else begin
      m_adr = adr;
      m_dat = dat;
      for (int i = 0; i < n; i++) q.push_back(mk(1'b1, we, 1'b1, 1'b0, 1'b0));
      if (k == 0) begin
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      end else begin
        if (!we) m_rdata = rd;
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      end
    end
    req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
    if (stray) begin ack_i = 1'b1; dat_i = 32'hFFFF_0000; end
    @(posedge clk_i); #1;
    ack_i = 1'b0; dat_i = 32'h0BAD_0BAD;
    if (!hold) req_i = 1'b0;
    if (legal) begin
      for (int i = 1; i <= n; i++) begin
        if (i == k) begin ack_i = 1'b1; dat_i = rd; end
        @(posedge clk_i); #1;
        ack_i = 1'b0; dat_i = 32'h0BAD_0BAD;
      end
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; req_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0;
    ack_i = 1'b0; dat_i = '0;
    repeat (3) @(posedge clk_i); #1;
    check("reset_cyc_busy_done_err", {cyc_o, stb_o, we_o, busy_o, done_o, err_o}, 64'h0);
    check("reset_adr_dat_rdata", {adr_o, dat_o ^ rdata_o}, 64'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    xfer(1'b1, 26'h0001234, 32'hDEADBEEF, 4, 32'h1111_1111, 1'b0, 1'b0);
    check("write_stb_cycles", last_run, 4);
    check("write_done_count", done_cnt, 1);
    check("write_err_count", err_cnt, 0);
    check("write_rdata_untouched", rdata_o, 32'h0);

    xfer(1'b0, 26'h0010001, 32'h7777_7777, 2, 32'hA5A5A5A5, 1'b0, 1'b0);
    check("read_rdata_held", rdata_o, 32'hA5A5A5A5);

    xfer(1'b1, 26'h0010001, 32'h1, 1, 32'h0, 1'b0, 1'b0);
    xfer(1'b0, 26'h0020000, 32'h2, 1, 32'h0, 1'b0, 1'b0);
    check("reject_err_count", err_cnt, 2);
    xfer(1'b0, 26'h0010000, 32'h3, 1, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 26'h0010002, 32'h4, 1, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 26'h0010000, 32'h0C0F_FEE0, 1, 32'h0, 1'b0, 1'b0);
    xfer(1'b0, 26'h000FFFF, 32'h5, 3, 32'h1234_5678, 1'b0, 1'b0);
    check("boundary_rdata", rdata_o, 32'h1234_5678);

    xfer(1'b0, 26'h0000010, 32'h6, 0, 32'h0, 1'b0, 1'b0);
    check("timeout_stb_cycles", last_run, 16);
    check("timeout_rdata_unchanged", rdata_o, 32'h1234_5678);

    ack_i = 1'b1; dat_i = 32'hEEEE_EEEE;
    @(posedge clk_i); #1;
    ack_i = 1'b0;

    xfer(1'b0, 26'h0000100, 32'h7, 4, 32'hCAFEF00D, 1'b1, 1'b0);
    xfer(1'b0, 26'h0000200, 32'h8, 3, 32'h0123_4567, 1'b0, 1'b1);
    check("held_req_gap", last_gap, 2);
    check("held_req_rdata", rdata_o, 32'h0123_4567);

    q.push_back(idle_exp());
    m_adr = 26'h0000ABC; m_dat = 32'h5555AAAA;
    for (int i = 0; i < TIMEOUT; i++) q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 26'h0000ABC; req_dat_i = 32'h5555AAAA;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    check("pre_reset_cyc", {cyc_o, busy_o}, 64'h3);
    #2;
    rst_i = 1'b0;
    q.delete();
    m_adr = '0; m_dat = '0; m_rdata = '0;
    #1;
    check("async_reset_cyc_stb_busy", {cyc_o, stb_o, busy_o}, 64'h0);
    repeat (2) @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i); #1;

    xfer(1'b1, 26'h00003FF, 32'h600D_600D, 1, 32'h0, 1'b0, 1'b0);
    check("final_done_count", done_cnt, 7);
    check("final_err_count", err_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
